// File: rtl/chu_spi_core.sv
// SPI master for one MMIO slot: full-duplex MSB-first 8-bit transfers with
// programmable divisor, CPOL/CPHA and software-driven active-low slave selects.
module chu_spi_core #(
  parameter int S = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [S-1:0] spi_ss_n
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPHA_DLY = 2'd1,
    P0       = 2'd2,
    P1       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   c_q, c_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [S-1:0]  ss_n_q, ss_n_d;
  logic [15:0]   dvsr_q, dvsr_d;
  logic          cpol_q, cpol_d;
  logic          cpha_q, cpha_d;

  logic          wr_en_s;
  logic          ready_s;
  logic          c_done_s;
  logic          p_clk_s;
  logic          unused_ok;

  // read strobe and upper address/data bits carry no meaning in this slot
  assign unused_ok = ^{read, addr[4:2], wr_data[31:18]};

  assign wr_en_s  = cs & write;
  assign ready_s  = (state_q == IDLE);
  assign c_done_s = (c_q == dvsr_q);

  // Register writes, transfer sequencing and shift registers
  always_comb begin
    state_d    = state_q;
    c_d        = c_q;
    n_d        = n_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    ss_n_d     = ss_n_q;
    dvsr_d     = dvsr_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;

    if (wr_en_s && (addr[1:0] == 2'd1)) begin
      ss_n_d = wr_data[S-1:0];
    end else begin
      ss_n_d = ss_n_q;
    end

    // mode and divisor may only change between transfers
    if (wr_en_s && (addr[1:0] == 2'd3) && ready_s) begin
      dvsr_d = wr_data[15:0];
      cpol_d = wr_data[16];
      cpha_d = wr_data[17];
    end else begin
      dvsr_d = dvsr_q;
    end

    case (state_q)
      IDLE: begin
        c_d = 16'd0;
        if (wr_en_s && (addr[1:0] == 2'd2)) begin
          tx_d    = wr_data[7:0];
          n_d     = 3'd0;
          state_d = cpha_q ? CPHA_DLY : P0;
        end else begin
          state_d = IDLE;
        end
      end
      CPHA_DLY: begin
        if (c_done_s) begin
          c_d     = 16'd0;
          state_d = P0;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P0: begin
        if (c_done_s) begin
          rx_shift_d = {rx_shift_q[6:0], spi_miso};
          c_d        = 16'd0;
          state_d    = P1;
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      P1: begin
        if (c_done_s) begin
          c_d = 16'd0;
          if (n_q == 3'd7) begin
            rx_data_d = rx_shift_q;
            state_d   = IDLE;
          end else begin
            tx_d    = {tx_q[6:0], 1'b0};
            n_d     = n_q + 3'd1;
            state_d = P0;
          end
        end else begin
          c_d = c_q + 16'd1;
        end
      end
      default: begin
        c_d     = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      c_q        <= 16'd0;
      n_q        <= 3'd0;
      tx_q       <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      ss_n_q     <= {S{1'b1}};
      dvsr_q     <= 16'h0200;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      n_q        <= n_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      ss_n_q     <= ss_n_d;
      dvsr_q     <= dvsr_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
    end
  end

  // leading SCLK edge sits at P1 entry for cpha=0 and at P0 entry for cpha=1
  assign p_clk_s  = ((state_q == P1) & ~cpha_q) | ((state_q == P0) & cpha_q);
  assign spi_sclk = p_clk_s ^ cpol_q;
  assign spi_mosi = tx_q[7];
  assign spi_ss_n = ss_n_q;
  assign rd_data  = {23'd0, ready_s, rx_data_q};

endmodule
